// File: rtl/clz_share_ctrl.sv
// Shares one 64-bit count-leading-zeros datapath between two requesters.
// Round-robin arbitration feeds a single-entry result stage that is tagged with its owner.
module clz_share_ctrl #(
    parameter int XLEN = 64,
    parameter int CNTW = 7
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic [XLEN-1:0] req0_data,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic [XLEN-1:0] req1_data,

    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [CNTW-1:0] resp_cnt,

    output logic            cg_en
);

    // Handshake: a transfer happens in a cycle where valid and ready are both high.
    // req*_ready may depend combinationally on req*_valid and resp*_ready, so a
    // requester must never make its valid depend on its ready.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FULL = 1'b1
    } state_e;

    state_e          state_q,      state_d;
    logic            owner_q,      owner_d;
    logic            last_grant_q, last_grant_d;
    logic [CNTW-1:0] cnt_q,        cnt_d;

    logic            resp_fire;
    logic            slot_free;
    logic            grant;
    logic            accept;
    logic [1:0]      sel_op;
    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] rev_data;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] norm;
    logic [CNTW-1:0] lz;
    logic [CNTW-1:0] clz_cnt;

    always_comb begin
        resp_fire = (state_q == S_FULL) && (owner_q ? resp1_ready : resp0_ready);
        slot_free = (state_q == S_IDLE) || resp_fire;
    end

    // With both or neither requester valid, the one not granted last time is preferred.
    always_comb begin
        grant = ~last_grant_q;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = !rst && slot_free && !grant;
    assign req1_ready = !rst && slot_free && grant;
    assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    assign cg_en      = accept;

    // Data is zeroed unless its requester is valid, so junk on an idle bus never reaches the count.
    always_comb begin
        sel_op   = grant ? req1_op : req0_op;
        sel_data = '0;
        if (grant && req1_valid) begin
            sel_data = req1_data;
        end else if (!grant && req0_valid) begin
            sel_data = req0_data;
        end
    end

    // ctz becomes clz of the reversed word; 32-bit ops pad the low half with ones to cap the count at 32.
    always_comb begin
        for (int i = 0; i < XLEN; i++) begin
            rev_data[i] = sel_data[XLEN-1-i];
        end
        case (sel_op)
            2'b00:   operand = sel_data;
            2'b01:   operand = {sel_data[XLEN/2-1:0], {(XLEN/2){1'b1}}};
            2'b10:   operand = rev_data;
            default: operand = {rev_data[XLEN-1:XLEN/2], {(XLEN/2){1'b1}}};
        endcase
    end

    // Binary-search normalizer: each stage decides one count bit and shifts the zeros out.
    always_comb begin
        norm = operand;
        lz   = '0;
        if (norm[63:32] == 32'h0) begin
            lz[5] = 1'b1;
            norm  = norm << 32;
        end
        if (norm[63:48] == 16'h0) begin
            lz[4] = 1'b1;
            norm  = norm << 16;
        end
        if (norm[63:56] == 8'h0) begin
            lz[3] = 1'b1;
            norm  = norm << 8;
        end
        if (norm[63:60] == 4'h0) begin
            lz[2] = 1'b1;
            norm  = norm << 4;
        end
        if (norm[63:62] == 2'h0) begin
            lz[1] = 1'b1;
            norm  = norm << 2;
        end
        if (!norm[63]) begin
            lz[0] = 1'b1;
        end
        clz_cnt = (operand == '0) ? CNTW'(XLEN) : lz;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        if (accept) begin
            state_d      = S_FULL;
            owner_d      = grant;
            last_grant_d = grant;
            cnt_d        = clz_cnt;
        end else if (resp_fire) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign resp0_valid = (state_q == S_FULL) && !owner_q;
    assign resp1_valid = (state_q == S_FULL) && owner_q;
    assign resp_cnt    = cnt_q;

    a_resp_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(resp0_valid && resp1_valid));

    a_resp0_hold: assert property (@(posedge clk) disable iff (rst)
        (resp0_valid && !resp0_ready) |=> (resp0_valid && $stable(resp_cnt)));

    a_resp1_hold: assert property (@(posedge clk) disable iff (rst)
        (resp1_valid && !resp1_ready) |=> (resp1_valid && $stable(resp_cnt)));

    a_no_ready_when_held: assert property (@(posedge clk) disable iff (rst)
        ((state_q == S_FULL) && !resp_fire) |-> !(req0_ready || req1_ready));

endmodule

// File: tb/tb_clz_share_ctrl.sv
// Bench for clz_share_ctrl: directed scenarios plus random traffic, checked by
// a queue-based scoreboard whose counts come from a plain bit-scan model.
module tb_clz_share_ctrl;

    localparam int XLEN = 64;
    localparam int CNTW = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [1:0]      req0_op, req1_op;
    logic [XLEN-1:0] req0_data, req1_data;
    logic            resp0_valid, resp1_valid;
    logic            resp0_ready, resp1_ready;
    logic [CNTW-1:0] resp_cnt;
    logic            cg_en;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entries are {owner, count}; at most one is outstanding.
    logic [CNTW:0] exp_q[$];
    logic          lg_m;

    clz_share_ctrl #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_data   (req1_data),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_cnt    (resp_cnt),
        .cg_en       (cg_en)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: scan for the first set bit, from the top for clz and from the bottom for ctz.
    function automatic logic [CNTW-1:0] ref_count(input logic [1:0] op, input logic [63:0] d);
        int w;
        int n;
        w = op[0] ? 32 : 64;
        n = 0;
        for (int k = 0; k < 64; k++) begin
            if (k < w) begin
                if (op[1] ? d[k] : d[w-1-k]) break;
                n++;
            end
        end
        return CNTW'(n);
    endfunction

    function automatic logic [63:0] rand_data();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: v = 64'h0;
            1: v = '1;
            2: v = 64'h1 << $urandom_range(0, 63);
            3: v = v >> $urandom_range(0, 63);
            4: v = v << $urandom_range(0, 63);
            default: ;
        endcase
        return v;
    endfunction

    // scoreboard / monitor: mid-cycle sample of the whole interface
    logic       m_full, m_own, m_fire, m_slot, m_any, m_g, m_acc;
    logic [1:0] m_op;
    logic [63:0] m_d;

    always @(negedge clk) begin
        if (!rst) begin
            m_full = (exp_q.size() != 0);
            m_own  = m_full ? exp_q[0][CNTW] : 1'b0;
            m_fire = m_full && (m_own ? resp1_ready : resp0_ready);
            m_slot = !m_full || m_fire;
            m_any  = req0_valid || req1_valid;
            if (req0_valid && req1_valid) m_g = ~lg_m;
            else                          m_g = req1_valid;
            m_acc  = m_any && m_slot;

            chk("resp0_valid", resp0_valid, m_full && !m_own);
            chk("resp1_valid", resp1_valid, m_full && m_own);
            if (m_full) chk("resp_cnt", resp_cnt, exp_q[0][CNTW-1:0]);
            if (m_any) begin
                chk("req0_ready", req0_ready, m_acc && !m_g);
                chk("req1_ready", req1_ready, m_acc && m_g);
            end
            chk("cg_en", cg_en, m_acc);

            if (m_fire) void'(exp_q.pop_front());
            if (m_acc) begin
                m_op = m_g ? req1_op : req0_op;
                m_d  = m_g ? req1_data : req0_data;
                exp_q.push_back({m_g, ref_count(m_op, m_d)});
                lg_m = m_g;
            end
        end
    end

    // driver tasks
    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_op    = 2'b00;
        req1_op    = 2'b00;
        req0_data  = 'x;
        req1_data  = 'x;
    endtask

    task automatic send(input int g, input logic [1:0] op, input logic [63:0] d);
        logic got;
        if (g == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_data = d;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_data = d;
        end
        got = 1'b0;
        for (int t = 0; t < 16 && !got; t++) begin
            @(negedge clk);
            got = (g == 0) ? req0_ready : req1_ready;
        end
        chk("send_accepted", got, 1'b1);
        @(posedge clk); #1;
        if (g == 0) begin
            req0_valid = 1'b0; req0_data = 'x;
        end else begin
            req1_valid = 1'b0; req1_data = 'x;
        end
    endtask

    // Called right after send(): the response must show in the very next cycle.
    task automatic expect_resp(input string name, input int g, input logic [CNTW-1:0] cnt);
        logic v;
        @(negedge clk);
        v = (g == 0) ? resp0_valid : resp1_valid;
        chk({name, "_valid"}, v, 1'b1);
        chk({name, "_cnt"}, resp_cnt, cnt);
        chk({name, "_cg_off"}, cg_en, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        lg_m = 1'b1;
        idle_inputs();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        #2;
        chk("rst_resp0_valid", resp0_valid, 1'b0);
        chk("rst_resp1_valid", resp1_valid, 1'b0);
        chk("rst_resp_cnt", resp_cnt, '0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 64'h1;
        req1_data  = 64'h1;
        #1;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_cg_en", cg_en, 1'b0);
        idle_inputs();
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        // latency, single requester
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        send(0, 2'b00, 64'h0000_0001_0000_0000);
        expect_resp("lat_clz64", 0, 7'd31);

        // op coverage on requester 1
        send(1, 2'b11, 64'hFFFF_FFFF_0000_0000);
        expect_resp("ctz32_zero_low", 1, 7'd32);
        send(1, 2'b10, 64'h8000_0000_0000_0000);
        expect_resp("ctz64_msb", 1, 7'd63);
        send(1, 2'b01, 64'h0000_0000_0000_8000);
        expect_resp("clz32_bit15", 1, 7'd16);
        send(1, 2'b00, 64'h0);
        expect_resp("clz64_zero", 1, 7'd64);
        send(0, 2'b00, '1);
        expect_resp("clz64_ones", 0, 7'd0);
        send(0, 2'b10, 64'h0);
        expect_resp("ctz64_zero", 0, 7'd64);

        // upper-half masking
        send(0, 2'b01, 64'hDEAD_BEEF_0000_00FF);
        expect_resp("clz32_mask", 0, 7'd24);

        // contention: both valid every cycle
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req0_op = 2'($urandom_range(0, 3)); req0_data = rand_data();
            req1_op = 2'($urandom_range(0, 3)); req1_data = rand_data();
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;

        // backpressure on requester 0 with requester 1 waiting
        resp0_ready = 1'b0;
        send(0, 2'b00, 64'h0000_0000_00F0_0000);
        req1_valid = 1'b1; req1_op = 2'b10; req1_data = 64'h0000_0000_0000_0100;
        repeat (3) begin @(posedge clk); end
        #1;
        resp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_req1_ready", req1_ready, 1'b1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("bp_resp1_valid", resp1_valid, 1'b1);
        chk("bp_resp1_cnt", resp_cnt, 7'd8);
        @(posedge clk); #1;

        // reset while a result is held
        resp0_ready = 1'b0;
        send(0, 2'b00, 64'h1);
        chk("pre_rst_valid", resp0_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid0", resp0_valid, 1'b0);
        chk("rst_async_valid1", resp1_valid, 1'b0);
        exp_q.delete();
        lg_m = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_data = rand_data();
        req1_valid = 1'b1; req1_op = 2'b10; req1_data = rand_data();
        @(negedge clk);
        chk("post_rst_grant0", req0_ready, 1'b1);
        chk("post_rst_no_grant1", req1_ready, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            req0_data = rand_data();
            req1_data = rand_data();
        end
        idle_inputs();
        @(posedge clk); #1;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            req0_valid  = ($urandom_range(0, 3) != 0);
            req1_valid  = ($urandom_range(0, 3) != 0);
            req0_op     = 2'($urandom_range(0, 3));
            req1_op     = 2'($urandom_range(0, 3));
            req0_data   = req0_valid ? rand_data() : 'x;
            req1_data   = req1_valid ? rand_data() : 'x;
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        idle_inputs();
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        repeat (3) begin @(posedge clk); end
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clz_share_ctrl.md
Name: clz_share_ctrl

Overview:
Shared-resource controller that time-multiplexes one 64-bit count-leading-zeros datapath between two CPU requesters. Requester 0 is the ALU bit-manip path (clz/clzw/ctz/ctzw). Requester 1 is the divider pre-normalization path. The block does the following:
- arbitrates round-robin between the two requesters;
- formats each operand for its op (32-bit word padding, bit reversal for ctz);
- drives the shared count-leading-zeros instance;
- holds the count in a single-entry result stage, tagged with its owner;
- returns the count over a per-requester valid/ready handshake.
It also exports a clock-gate enable for the result register.

Parameters:
XLEN, 64, operand width. Only 64 is supported.
CNTW, 7, result count width (log2(XLEN)+1).

Ports:
clk  input  1  core clock.
rst  input  1  asynchronous reset, active-high.
req0_valid  input  1  requester 0 has an operand.
req0_ready  output  1  requester 0 operand accepted this cycle.
req0_op  input  2  00 clz64, 01 clz32, 10 ctz64, 11 ctz32.
req0_data  input  XLEN  requester 0 operand.
req1_valid / req1_ready / req1_op / req1_data  same as requester 0, for requester 1.
resp0_valid  output  1  result for requester 0 is valid.
resp0_ready  input  1  requester 0 takes the result.
resp1_valid  output  1  result for requester 1 is valid.
resp1_ready  input  1  requester 1 takes the result.
resp_cnt  output  CNTW  count; shared bus, qualified by resp0_valid or resp1_valid.
cg_en  output  1  enable for the result-register clock gate; high in any cycle a request is accepted.

Behaviour:
- Reset values: req0_ready=req1_ready=0, resp0_valid=resp1_valid=0, resp_cnt=0, cg_en=0, internal state IDLE, last_grant=1 (so requester 0 wins the first contention).
- State machine has two states:
  - IDLE: result stage empty.
  - FULL: result stage holds a count plus an owner bit.
- Response fire: resp_fire = FULL & resp<owner>_ready.
- Slot free: slot_free = IDLE | resp_fire. The stage drains and refills in the same cycle; full throughput is 1 op/cycle.
- Grant:
  - Only one requester valid: that requester.
  - Both valid: the requester other than last_grant.
  - req<g>_ready = grant<g> & slot_free. The ready of the non-granted requester is 0.
- Accept: accept = req<g>_valid & req<g>_ready. On accept:
  - latch the count and owner=g;
  - set last_grant=g;
  - cg_en=1;
  - state becomes (or stays) FULL.
- Drain without accept: resp_fire with no accept moves FULL to IDLE.
- No accept: last_grant holds.
- Latency: operand accepted in cycle N gives resp<g>_valid high from cycle N+1.
- Holding a result: resp_cnt and owner stay stable while resp<g>_valid=1 and resp<g>_ready=0. req*_ready stays 0 during this time.
- Only the owner's resp_valid can be high; the two resp_valid outputs are never high together.
- Combinational paths:
  - req*_ready depends combinationally on req*_valid and resp*_ready.
  - Requesters must not make valid depend on ready.
  - There is no combinational path from req*_data to any output.
- Operand formatting. rev() is bit reversal; count = clz64(operand):
  - clz64: operand = data.
  - clz32: operand = {data[31:0], 32'hFFFF_FFFF}.
  - ctz64: operand = rev(data).
  - ctz32: operand = {rev(data[31:0]), 32'hFFFF_FFFF}.
  - Bits [63:32] are ignored for the 32-bit ops.
- Boundary counts:
  - data=0 gives 64 for clz64 and ctz64.
  - Zero lower word gives 32 for clz32 and ctz32.
  - Full-width all-ones gives 0.
- The count-leading-zeros datapath is combinational between the operand mux and the result register. It lies inside the capture cycle; there is no extra pipeline stage.
- rst asserted mid-operation: any pending result is dropped with no response. State returns to IDLE and last_grant to 1 immediately (asynchronous). The first accept after reset release occurs no earlier than the first clk edge with rst=0.
- X on req*_data while req*_valid=0 must not propagate to resp_cnt.

Test Plan:
1. Latency, single requester: req0 clz64 data=64'h0000_0001_0000_0000, resp0_ready=1 -> req0_ready=1 in cycle N; resp0_valid=1 with resp_cnt=31 in N+1; cg_en=1 in N only.
2. Op coverage, requester 1:
   - ctz32 data=64'hFFFF_FFFF_0000_0000 -> 32.
   - ctz64 data=64'h8000_0000_0000_0000 -> 63.
   - clz32 data=64'h0000_0000_0000_8000 -> 16.
   - clz64 data=0 -> 64.
3. Contention: both valid continuously with resp*_ready=1 -> grants alternate 0,1,0,1. Each response carries the correct owner's count, throughput 1/cycle, and neither resp_valid is high with the other.
4. Backpressure: req0 accepted, resp0_ready=0 for 3 cycles -> resp0_valid and resp_cnt stable, req0_ready=req1_ready=0. resp0_ready=1 with req1 valid -> req1 accepted in the same cycle; resp1_valid follows the next cycle.
5. Reset mid-operation: rst pulsed while FULL with resp0_ready=0 -> resp0_valid=0 asynchronously, no response delivered. After release with both valid, requester 0 is granted first.
6. Upper-half masking: req0 clz32 data=64'hDEAD_BEEF_0000_00FF -> 24, unaffected by bits [63:32].
